quad_bbox_scanner: RTL and testbench

// - Sits directly downstream of the origin-shift stage. Takes the four shifted quad

---
 rtl/quad_bbox_scanner.sv | 200 ++++++++++++++++++++
 tb/tb_quad_bbox_scanner.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_bbox_scanner.sv
// Quad bounding-box scanner: floors and clamps the quad's bbox, then streams its pixels row-major.
// Optional pix_count output enabled by defining QBS_PIX_COUNT_EN.
module quad_bbox_scanner #(
   parameter int SCR_W = 640,
   parameter int SCR_H = 480,
   parameter int FRAC  = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] vtx1_X,
   input  logic [15:0] vtx2_X,
   input  logic [15:0] vtx3_X,
   input  logic [15:0] vtx4_X,
   input  logic [15:0] vtx1_Y,
   input  logic [15:0] vtx2_Y,
   input  logic [15:0] vtx3_Y,
   input  logic [15:0] vtx4_Y,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic [9:0]  pix_x,
   output logic [8:0]  pix_y,
   output logic        pix_last,
   output logic        quad_done,
`ifdef QBS_PIX_COUNT_EN
   output logic [18:0] pix_count,
`endif
   output logic        busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SETUP = 2'd1;
   localparam logic [1:0] S_SCAN  = 2'd2;

   localparam logic signed [16:0] XLIM = 17'(SCR_W - 1);
   localparam logic signed [16:0] YLIM = 17'(SCR_H - 1);
   localparam logic signed [16:0] ZERO = 17'sd0;

   logic [1:0]  state;
   logic [15:0] vx [4];
   logic [15:0] vy [4];

   logic [9:0]  xmin, xmax, cx;
   logic [8:0]  ymin, ymax, cy;

   logic signed [16:0] fx [4];
   logic signed [16:0] fy [4];
   logic signed [16:0] bxmin, bxmax, bymin, bymax;
   logic signed [16:0] cxmin, cxmax, cymin, cymax;
   logic               empty;
   logic               hs;
   logic               at_last;

   // Integer part of a fixed-point coordinate: sign-extend, then arithmetic shift (floor).
   function automatic logic signed [16:0] flr(input logic [15:0] v);
      logic signed [16:0] t;
      t = {v[15], v};
      return t >>> FRAC;
   endfunction

   // Floor every registered vertex coordinate.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         fx[i] = flr(vx[i]);
         fy[i] = flr(vy[i]);
      end
   end

   // Unclamped bbox as min/max over the four floored vertices.
   always_comb begin
      bxmin = fx[0];
      bxmax = fx[0];
      bymin = fy[0];
      bymax = fy[0];
      for (int i = 1; i < 4; i++) begin
         if (fx[i] < bxmin) bxmin = fx[i];
         if (fx[i] > bxmax) bxmax = fx[i];
         if (fy[i] < bymin) bymin = fy[i];
         if (fy[i] > bymax) bymax = fy[i];
      end
   end

   // Empty test on the raw box, then clamp to the screen.
   always_comb begin
      empty = (bxmax < ZERO) || (bymax < ZERO) ||
              (bxmin > XLIM) || (bymin > YLIM);
      cxmin = (bxmin < ZERO) ? ZERO : bxmin;
      cxmax = (bxmax > XLIM) ? XLIM : bxmax;
      cymin = (bymin < ZERO) ? ZERO : bymin;
      cymax = (bymax > YLIM) ? YLIM : bymax;
   end

   // Upper bits of the clamped box are zero for any non-empty quad.
   logic unused_hi;
   assign unused_hi = ^{cxmin[16:10], cxmax[16:10], cymin[16:9], cymax[16:9]};

   // Pixel-stream outputs decoded from state and scan position.
   always_comb begin
      in_ready  = (state == S_IDLE);
      busy      = (state != S_IDLE);
      pix_valid = (state == S_SCAN);
      pix_x     = cx;
      pix_y     = cy;
      at_last   = (cx == xmax) && (cy == ymax);
      pix_last  = pix_valid && at_last;
      hs        = pix_valid && pix_ready;
   end

   // Vertex capture on accept; only X/Y are kept.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            vx[i] <= '0;
            vy[i] <= '0;
         end
      end else if (in_valid && in_ready) begin
         vx[0] <= vtx1_X;
         vx[1] <= vtx2_X;
         vx[2] <= vtx3_X;
         vx[3] <= vtx4_X;
         vy[0] <= vtx1_Y;
         vy[1] <= vtx2_Y;
         vy[2] <= vtx3_Y;
         vy[3] <= vtx4_Y;
      end
   end

   // Control FSM: accept, one setup cycle, then raster scan of the box.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         quad_done <= 1'b0;
      end else begin
         quad_done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (in_valid) state <= S_SETUP;
            end
            S_SETUP: begin
               if (empty) begin
                  quad_done <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  state <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (hs && at_last) begin
                  quad_done <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Clamped bbox latch and scan cursor.
   always_ff @(posedge clk) begin
      if (rst) begin
         xmin <= '0;
         xmax <= '0;
         ymin <= '0;
         ymax <= '0;
         cx   <= '0;
         cy   <= '0;
      end else if (state == S_SETUP) begin
         if (!empty) begin
            xmin <= cxmin[9:0];
            xmax <= cxmax[9:0];
            ymin <= cymin[8:0];
            ymax <= cymax[8:0];
            cx   <= cxmin[9:0];
            cy   <= cymin[8:0];
         end
      end else if (hs && !at_last) begin
         if (cx < xmax) begin
            cx <= cx + 10'd1;
         end else begin
            cx <= xmin;
            cy <= cy + 9'd1;
         end
      end
   end

`ifdef QBS_PIX_COUNT_EN
   // Pixels emitted for the current or most recent quad.
   always_ff @(posedge clk) begin
      if (rst) begin
         pix_count <= '0;
      end else if (in_valid && in_ready) begin
         pix_count <= '0;
      end else if (hs) begin
         pix_count <= pix_count + 19'd1;
      end
   end
`endif

endmodule

// File: tb/tb_quad_bbox_scanner.sv
// Bench for quad_bbox_scanner: directed cases plus random quads against a pixel-list model.
// Covers QBS_PIX_COUNT_EN when that macro is defined.
module tb_quad_bbox_scanner;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] qx [4];
   logic [15:0] qy [4];
   logic        pix_valid;
   logic        pix_ready;
   logic [9:0]  pix_x;
   logic [8:0]  pix_y;
   logic        pix_last;
   logic        quad_done;
   logic        busy;
`ifdef QBS_PIX_COUNT_EN
   logic [18:0] pix_count;
`endif

   int checks = 0;
   int errors = 0;

   int ex_x [$];
   int ex_y [$];
   int m_total;
   bit m_empty;

   always #5 clk = ~clk;

   quad_bbox_scanner dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .vtx1_X    (qx[0]),
      .vtx2_X    (qx[1]),
      .vtx3_X    (qx[2]),
      .vtx4_X    (qx[3]),
      .vtx1_Y    (qy[0]),
      .vtx2_Y    (qy[1]),
      .vtx3_Y    (qy[2]),
      .vtx4_Y    (qy[3]),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .pix_last  (pix_last),
      .quad_done (quad_done),
`ifdef QBS_PIX_COUNT_EN
      .pix_count (pix_count),
`endif
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Mathematical floor of v/32 for a signed fixed-point value.
   function automatic int fdiv(input int s);
      if (s >= 0) return s / 32;
      return -((-s + 31) / 32);
   endfunction

   // Expected pixel list for the vertices currently on qx/qy.
   task automatic build_model();
      int xs [4];
      int ys [4];
      int xmn, xmx, ymn, ymx;
      for (int i = 0; i < 4; i++) begin
         xs[i] = fdiv(int'($signed(qx[i])));
         ys[i] = fdiv(int'($signed(qy[i])));
      end
      xmn = xs[0]; xmx = xs[0]; ymn = ys[0]; ymx = ys[0];
      for (int i = 1; i < 4; i++) begin
         xmn = (xs[i] < xmn) ? xs[i] : xmn;
         xmx = (xs[i] > xmx) ? xs[i] : xmx;
         ymn = (ys[i] < ymn) ? ys[i] : ymn;
         ymx = (ys[i] > ymx) ? ys[i] : ymx;
      end
      ex_x.delete();
      ex_y.delete();
      m_empty = (xmx < 0) || (ymx < 0) || (xmn > 639) || (ymn > 479);
      if (!m_empty) begin
         if (xmn < 0) xmn = 0;
         if (ymn < 0) ymn = 0;
         if (xmx > 639) xmx = 639;
         if (ymx > 479) ymx = 479;
         for (int y = ymn; y <= ymx; y++)
            for (int x = xmn; x <= xmx; x++) begin
               ex_x.push_back(x);
               ex_y.push_back(y);
            end
      end
      m_total = ex_x.size();
   endtask

   task automatic set_quad(input logic [63:0] xv, input logic [63:0] yv);
      for (int i = 0; i < 4; i++) begin
         qx[i] = xv[63 - 16*i -: 16];
         qy[i] = yv[63 - 16*i -: 16];
      end
   endtask

   // mode 0: always ready, 1: ready pattern 1,0,0, 2: random ready with in_valid held high.
   task automatic run_quad(input string nm, input int mode, input int abort_at);
      int  cyc, hs, budget, px, py;
      bit  stall;
      build_model();
      @(negedge clk);
      chk({nm, ".in_ready"}, 32'(in_ready), 1);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         qx[i] = 16'($urandom);
         qy[i] = 16'($urandom);
      end
      chk({nm, ".setup_busy"}, 32'(busy), 1);
      chk({nm, ".setup_valid"}, 32'(pix_valid), 0);
      chk({nm, ".setup_in_ready"}, 32'(in_ready), 0);
      @(negedge clk);
      chk({nm, ".lat_valid"}, 32'(pix_valid), 32'(!m_empty));
      chk({nm, ".lat_done"}, 32'(quad_done), 32'(m_empty));
      if (m_empty) begin
         chk({nm, ".empty_in_ready"}, 32'(in_ready), 1);
         @(negedge clk);
         chk({nm, ".empty_done_pulse"}, 32'(quad_done), 0);
         chk({nm, ".empty_busy"}, 32'(busy), 0);
         return;
      end
      budget = 4 * ex_x.size() + 16;
      cyc = 0; hs = 0; stall = 1'b0; px = 0; py = 0;
      if (mode == 2) in_valid = 1'b1;
      while (ex_x.size() > 0 && cyc < budget) begin
         if (stall) begin
            chk({nm, ".stall_x"}, 32'(pix_x), px);
            chk({nm, ".stall_y"}, 32'(pix_y), py);
         end
         chk({nm, ".scan_done"}, 32'(quad_done), 0);
         case (mode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = (cyc % 3 == 0);
            default: pix_ready = 1'($urandom_range(0, 1));
         endcase
         if (!pix_valid) begin
            chk({nm, ".scan_valid"}, 32'(pix_valid), 1);
         end else if (pix_ready) begin
            chk({nm, ".pix_x"}, 32'(pix_x), ex_x[0]);
            chk({nm, ".pix_y"}, 32'(pix_y), ex_y[0]);
            chk({nm, ".pix_last"}, 32'(pix_last), 32'(ex_x.size() == 1));
            void'(ex_x.pop_front());
            void'(ex_y.pop_front());
            hs++;
         end
         stall = pix_valid && !pix_ready;
         px = int'(pix_x);
         py = int'(pix_y);
         @(negedge clk);
         cyc++;
         if (abort_at > 0 && hs == abort_at) begin
            pix_ready = 1'b0;
            in_valid  = 1'b0;
            rst       = 1'b1;
            @(negedge clk);
            chk({nm, ".abort_valid"}, 32'(pix_valid), 0);
            chk({nm, ".abort_busy"}, 32'(busy), 0);
            chk({nm, ".abort_in_ready"}, 32'(in_ready), 1);
            chk({nm, ".abort_done"}, 32'(quad_done), 0);
            chk({nm, ".abort_x"}, 32'(pix_x), 0);
            chk({nm, ".abort_last"}, 32'(pix_last), 0);
`ifdef QBS_PIX_COUNT_EN
            chk({nm, ".abort_count"}, 32'(pix_count), 0);
`endif
            rst = 1'b0;
            ex_x.delete();
            ex_y.delete();
            return;
         end
      end
      in_valid  = 1'b0;
      pix_ready = 1'b0;
      chk({nm, ".timeout_left"}, ex_x.size(), 0);
      chk({nm, ".end_valid"}, 32'(pix_valid), 0);
      chk({nm, ".end_done"}, 32'(quad_done), 1);
      chk({nm, ".end_in_ready"}, 32'(in_ready), 1);
`ifdef QBS_PIX_COUNT_EN
      chk({nm, ".count"}, 32'(pix_count), m_total);
`endif
      @(negedge clk);
      chk({nm, ".done_pulse"}, 32'(quad_done), 0);
      chk({nm, ".idle_busy"}, 32'(busy), 0);
`ifdef QBS_PIX_COUNT_EN
      chk({nm, ".count_hold"}, 32'(pix_count), m_total);
`endif
   endtask

   initial begin
      int cxp, cyp, v;
      rst = 1'b1;
      in_valid = 1'b0;
      pix_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         qx[i] = '0;
         qy[i] = '0;
      end
      repeat (3) @(negedge clk);
      chk("rst.in_ready", 32'(in_ready), 1);
      chk("rst.pix_valid", 32'(pix_valid), 0);
      chk("rst.pix_x", 32'(pix_x), 0);
      chk("rst.pix_y", 32'(pix_y), 0);
      chk("rst.pix_last", 32'(pix_last), 0);
      chk("rst.quad_done", 32'(quad_done), 0);
      chk("rst.busy", 32'(busy), 0);
`ifdef QBS_PIX_COUNT_EN
      chk("rst.pix_count", 32'(pix_count), 0);
`endif
      rst = 1'b0;

      set_quad(64'h2800_2840_2840_2800, 64'h1E00_1E00_1E20_1E20);
      run_quad("basic", 0, 0);

      set_quad(64'h2800_2840_2840_2800, 64'h1E00_1E00_1E20_1E20);
      run_quad("bp", 1, 0);

      set_quad(64'hFF00_0040_0040_FFFF, 64'h0000_0000_0000_0000);
      run_quad("clamp", 0, 0);

      set_quad(64'h5100_5100_5100_5100, 64'h1E00_1E00_1E00_1E00);
      run_quad("empty", 0, 0);

      set_quad(64'h0020_0020_0020_0020, 64'h0020_0020_0020_0020);
      run_quad("single", 1, 0);

      set_quad(64'h2800_2840_2840_2800, 64'h1E00_1E00_1E20_1E20);
      run_quad("abort", 0, 2);

      set_quad(64'h2800_2840_2840_2800, 64'h1E00_1E00_1E20_1E20);
      run_quad("after_abort", 0, 0);

      set_quad(64'h8000_7FFF_7FFF_8000, 64'h0000_0000_0000_0000);
      run_quad("extreme", 0, 0);

      set_quad(64'h0000_0000_0000_0000, 64'h8000_8000_FFE0_FFE0);
      run_quad("neg_y_empty", 0, 0);

      for (int n = 0; n < 30; n++) begin
         cxp = int'($urandom_range(0, 720)) - 40;
         cyp = int'($urandom_range(0, 560)) - 40;
         for (int i = 0; i < 4; i++) begin
            v = cxp * 32 + int'($urandom_range(0, 320)) - 160;
            qx[i] = v[15:0];
            v = cyp * 32 + int'($urandom_range(0, 320)) - 160;
            qy[i] = v[15:0];
         end
         run_quad("rand", 2, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
